// File: rtl/raisin64_mem_pkg.sv
// Shared types for the raisin64 data-memory arbiter.
// FSM states, owner encoding and bus widths.
package raisin64_mem_pkg;

  localparam int DATA_W = 64;
  localparam int BE_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// Winner select for the dmem arbiter: CPU first,
// debug forced after too many back-to-back CPU wins.
module dmem_arb_pick
  import raisin64_mem_pkg::*;
#(
  parameter int DBG_STARVE_MAX = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   cpu_req,
  input  logic   dbg_req,
  input  logic   grant_en,
  output logic   grant,
  output owner_t winner
);

  localparam int CNT_W = $clog2(DBG_STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DBG_STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic             dbg_win;

  assign dbg_win = dbg_req && (!cpu_req || starve_cnt == CNT_MAX);
  assign grant   = cpu_req || dbg_req;
  assign winner  = dbg_win ? OWN_DBG : OWN_CPU;

  // Count CPU wins that bypassed a waiting debug request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!dbg_req) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (dbg_win)
        starve_cnt <= '0;
      else if (starve_cnt != CNT_MAX)
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter between CPU LSU and debug.
// One transaction at a time: IDLE/ISSUE/WAIT/RESP.
module dmem_arbiter
  import raisin64_mem_pkg::*;
#(
  parameter int ADDR_W         = 64,
  parameter int MEM_LATENCY    = 1,
  parameter int DBG_STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [BE_W-1:0]   cpu_be,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic [BE_W-1:0]   dbg_be,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [BE_W-1:0]   mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] LAT_INIT = 2'(MEM_LATENCY - 1);

  arb_state_t state;
  owner_t     owner;
  owner_t     winner;
  logic [1:0] lat_cnt;
  logic       grant;
  logic       idle;

  assign idle = (state == S_IDLE);
  assign busy = !idle;

  dmem_arb_pick #(
    .DBG_STARVE_MAX(DBG_STARVE_MAX)
  ) u_pick (
    .clk     (clk),
    .rst_n   (rst_n),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .grant_en(idle),
    .grant   (grant),
    .winner  (winner)
  );

  // Transaction sequencer with registered memory strobe and acks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      owner     <= OWN_CPU;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
    end else begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            owner  <= winner;
            mem_en <= 1'b1;
            state  <= S_ISSUE;
            if (winner == OWN_DBG) begin
              mem_we    <= dbg_we;
              mem_addr  <= dbg_addr;
              mem_wdata <= dbg_wdata;
              mem_be    <= dbg_be;
            end else begin
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_be    <= cpu_be;
            end
          end
        end
        S_ISSUE: begin
          lat_cnt <= LAT_INIT;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == 2'd0) begin
            state <= S_RESP;
            if (owner == OWN_DBG) begin
              dbg_rdata <= mem_rdata;
              dbg_ack   <= 1'b1;
            end else begin
              cpu_rdata <= mem_rdata;
              cpu_ack   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter.
// Reference schedules grants from the arbitration rules.
module tb_dmem_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 2;
  localparam int AW   = 64;
  localparam int NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [63:0]   cpu_wdata = '0;
  logic [7:0]    cpu_be = '0;
  logic          cpu_ack;
  logic [63:0]   cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [63:0]   dbg_wdata = '0;
  logic [7:0]    dbg_be = '0;
  logic          dbg_ack;
  logic [63:0]   dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [7:0]    mem_be;
  logic [63:0]   mem_rdata = '0;
  logic          busy;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(AW), .MEM_LATENCY(LAT), .DBG_STARVE_MAX(SMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_be(dbg_be),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic [63:0] rdata;
  } ev_t;

  ev_t q_mem[$];
  ev_t q_cpu[$];
  ev_t q_dbg[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int busy_lo = 0;
  int busy_hi = -1;
  int free_at = 0;
  int starve = 0;
  int last_g = -100;
  int n_force = 0;
  bit did_rst = 0;

  logic [63:0] env_mem[8];
  logic [63:0] ref_mem[8];
  logic [63:0] pend_data;
  int          pend_due;
  bit          pend_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old,
                                        input logic [63:0] wd,
                                        input logic [7:0]  be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory environment: reads return pre-write contents
  // and are visible only in the cycle LAT after mem_en.
  always @(negedge clk) begin
    if (rst_n && mem_en) begin
      pend_data = env_mem[mem_addr[5:3]];
      if (mem_we)
        env_mem[mem_addr[5:3]] =
          merge(env_mem[mem_addr[5:3]], mem_wdata, mem_be);
      pend_due = cyc + LAT;
      pend_v = 1;
    end
    if (pend_v && pend_due == cyc) begin
      mem_rdata = pend_data;
      pend_v = 0;
    end else begin
      mem_rdata = {$urandom, $urandom};
    end
  end

  // Monitor: compares DUT outputs with scoreboard queues
  logic [63:0] cpu_hold = '0;
  logic [63:0] dbg_hold = '0;
  ev_t me;
  bit  exp_en, exp_ca, exp_da;

  always @(negedge clk) begin
    if (!rst_n) begin
      cpu_hold = '0;
      dbg_hold = '0;
    end else begin
      chk("busy", busy, 64'(cyc >= busy_lo && cyc <= busy_hi));
      exp_en = q_mem.size() > 0 && q_mem[0].cyc == cyc;
      chk("mem_en", mem_en, 64'(exp_en));
      if (exp_en) begin
        me = q_mem.pop_front();
        if (mem_en) begin
          chk("mem_we", mem_we, 64'(me.we));
          chk("mem_addr", mem_addr, me.addr);
          chk("mem_wdata", mem_wdata, me.wdata);
          chk("mem_be", mem_be, 64'(me.be));
        end
      end
      exp_ca = q_cpu.size() > 0 && q_cpu[0].cyc == cyc;
      chk("cpu_ack", cpu_ack, 64'(exp_ca));
      if (exp_ca) begin
        me = q_cpu.pop_front();
        cpu_hold = me.rdata;
        if (cpu_ack) begin
          chk("cpu_rdata", cpu_rdata, me.rdata);
          chk("dbg_rdata_hold", dbg_rdata, dbg_hold);
        end
      end
      exp_da = q_dbg.size() > 0 && q_dbg[0].cyc == cyc;
      chk("dbg_ack", dbg_ack, 64'(exp_da));
      if (exp_da) begin
        me = q_dbg.pop_front();
        dbg_hold = me.rdata;
        if (dbg_ack) begin
          chk("dbg_rdata", dbg_rdata, me.rdata);
          chk("cpu_rdata_hold", cpu_rdata, cpu_hold);
        end
      end
    end
  end

  // Stimulus, reference scheduler and reset injection
  ev_t ge;
  bit  dw;

  initial begin
    for (int i = 0; i < 8; i++) begin
      env_mem[i] = {$urandom, $urandom};
      ref_mem[i] = env_mem[i];
    end
    env_mem[2] = 64'hDEADBEEF_00000001;
    ref_mem[2] = env_mem[2];

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);

      if (cpu_req) begin
        if (cpu_ack) begin
          if (i < NCYC - 40 && $urandom_range(0, 3) != 0) begin
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = 64'($urandom_range(0, 7)) << 3;
            cpu_wdata = {$urandom, $urandom};
            cpu_be    = 8'($urandom);
          end else begin
            cpu_req = 1'b0;
          end
        end
      end else if (i < NCYC - 40 && $urandom_range(0, 2) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 64'($urandom_range(0, 7)) << 3;
        cpu_wdata = {$urandom, $urandom};
        cpu_be    = 8'($urandom);
      end

      if (dbg_req) begin
        if (dbg_ack) begin
          if (i < NCYC - 40 && $urandom_range(0, 1) == 0) begin
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = 64'($urandom_range(0, 7)) << 3;
            dbg_wdata = {$urandom, $urandom};
            dbg_be    = 8'($urandom);
          end else begin
            dbg_req = 1'b0;
          end
        end
      end else if (i < NCYC - 40 && $urandom_range(0, 3) == 0) begin
        dbg_req   = 1'b1;
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_addr  = 64'($urandom_range(0, 7)) << 3;
        dbg_wdata = {$urandom, $urandom};
        dbg_be    = 8'($urandom);
      end

      if (cyc >= free_at && (cpu_req || dbg_req)) begin
        dw = dbg_req && (!cpu_req || starve == SMAX);
        if (dw && cpu_req) n_force++;
        ge.we    = dw ? dbg_we : cpu_we;
        ge.addr  = dw ? dbg_addr : cpu_addr;
        ge.wdata = dw ? dbg_wdata : cpu_wdata;
        ge.be    = dw ? dbg_be : cpu_be;
        ge.rdata = ref_mem[ge.addr[5:3]];
        if (ge.we)
          ref_mem[ge.addr[5:3]] =
            merge(ref_mem[ge.addr[5:3]], ge.wdata, ge.be);
        ge.cyc = cyc + 1;
        q_mem.push_back(ge);
        ge.cyc = cyc + 2 + LAT;
        if (dw) q_dbg.push_back(ge);
        else    q_cpu.push_back(ge);
        busy_lo = cyc + 1;
        busy_hi = cyc + 2 + LAT;
        free_at = cyc + 3 + LAT;
        last_g  = cyc;
        if (dw) starve = 0;
        else if (dbg_req && starve < SMAX) starve++;
      end
      if (!dbg_req) starve = 0;

      if (!did_rst && i > 1500 && cyc == last_g + 3) begin
        #2;
        chk("busy_before_rst", busy,
            64'(cyc >= busy_lo && cyc <= busy_hi));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_cpu_ack", cpu_ack, 0);
        chk("midrst_dbg_ack", dbg_ack, 0);
        chk("midrst_cpu_rdata", cpu_rdata, 0);
        chk("midrst_dbg_rdata", dbg_rdata, 0);
        q_mem.delete();
        q_cpu.delete();
        q_dbg.delete();
        pend_v  = 0;
        busy_hi = -1;
        free_at = 0;
        starve  = 0;
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n   = 1'b1;
        did_rst = 1;
      end
    end

    chk("queues_drained",
        64'(q_mem.size() + q_cpu.size() + q_dbg.size()), 0);
    $display("forced debug grants: %0d", n_force);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port data memory (dmem) between two requesters: the CPU load/store unit and the JTAG debug master.
- CPU has fixed priority.
- A starvation counter forces a debug grant after a bounded number of back-to-back CPU wins.
- Sits between the core/debug unit and the dmem instance inside raisin64; sequences one memory transaction at a time and returns read data with a one-cycle ack pulse.

Parameters:
ADDR_W, 64, byte-address width on all address ports
MEM_LATENCY, 1, cycles from mem_en to valid mem_rdata (legal range 1..4)
DBG_STARVE_MAX, 8, consecutive CPU grants while dbg_req is pending before debug is forced (legal range >=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU request; held until cpu_ack
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  byte address
cpu_wdata  in  64  write data
cpu_be  in  8  byte enables
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  64  read data, valid when cpu_ack=1
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_be  in  1/1/ADDR_W/64/8  debug master request, same rules as CPU
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  64  read data, valid when dbg_ack=1
mem_en  out  1  memory access strobe, one cycle per transaction
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  64  memory write data
mem_be  out  8  memory byte enables
mem_rdata  in  64  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: clk only; rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state=IDLE, starve_cnt=0, rdata regs=0.
- FSM states: IDLE -> ISSUE -> WAIT (MEM_LATENCY cycles) -> RESP -> IDLE.
- IDLE, cycle N:
  - If any req is high, pick a winner and latch its we/addr/wdata/be and the owner bit; go to ISSUE.
  - If no req, stay in IDLE.
- Winner selection:
  - dbg wins if dbg_req && (!cpu_req || starve_cnt==DBG_STARVE_MAX).
  - Otherwise cpu wins if cpu_req.
- ISSUE, cycle N+1: mem_en=1, mem_* driven from latches; go to WAIT with latency counter = MEM_LATENCY-1.
- WAIT: counts down. In the cycle where the counter reaches 0 (cycle N+1+MEM_LATENCY), capture mem_rdata into the owner's rdata register; go to RESP.
- RESP, cycle N+2+MEM_LATENCY: owner's ack=1 for exactly one cycle; go to IDLE.
  - With MEM_LATENCY=1: req seen at N, ack at N+3.
  - Peak throughput: one transaction per 3+MEM_LATENCY cycles.
- Writes: same timing; rdata of the owner still updates from mem_rdata (don't-care contents).
- Non-owner rdata holds its last value.
- mem_we/addr/wdata/be: hold their latched values outside ISSUE; only mem_en qualifies them.
- starve_cnt:
  - Updated only on an IDLE grant.
  - CPU granted while dbg_req=1: increment, saturating at DBG_STARVE_MAX.
  - dbg granted: clear to 0.
  - Any cycle with dbg_req=0: clear to 0.
- Requester rules:
  - req and its payload must be stable from assertion until ack.
  - A req still high in the cycle after RESP is treated as a new request.
  - A req dropped before grant is ignored.
  - A req dropped after grant does not abort the transaction; the ack still pulses.
- Simultaneous requests: exactly one grant per IDLE cycle; the loser's req is retained and served next.
- Reset mid-transaction: asynchronous return to IDLE; ack, mem_en and busy drop immediately; the in-flight access is lost with no ack.

Decomposition:
- raisin64_mem_pkg holds: data width 64, BE width 8, the FSM state enum (IDLE/ISSUE/WAIT/RESP), and the owner encoding (OWN_CPU=0, OWN_DBG=1).
- One sub-module, dmem_arb_pick: combinational winner select plus the starve_cnt register, parameterised by DBG_STARVE_MAX.

Test Plan:
- CPU read alone: mem preset addr 0x10=0xDEADBEEF00000001; cpu_req read at N -> mem_en at N+1 with mem_addr=0x10; cpu_ack at N+3 with cpu_rdata=0xDEADBEEF00000001; dbg_ack stays 0.
- Debug write then CPU read: dbg writes 0x55 to 0x20 with be=0x01 -> dbg_ack once, mem_we=1 at ISSUE; CPU then reads 0x20 -> low byte 0x55.
- Simultaneous requests: cpu_req and dbg_req both rise at N -> CPU granted (mem_en at N+1, cpu_ack at N+3); dbg granted at the next IDLE (mem_en at N+5, dbg_ack at N+7).
- Starvation, DBG_STARVE_MAX=2: cpu_req held continuously with dbg_req high -> grant order CPU, CPU, DBG, CPU; starve_cnt returns to 0 after the debug grant.
- MEM_LATENCY=3: single CPU read at N -> mem_en at N+1, cpu_ack at N+5, busy high N+1..N+5.
- Reset mid-WAIT: rst_n low during WAIT -> busy, mem_en and acks go to 0 immediately; after release, a fresh cpu_req completes normally with correct data.
